// File: rtl/vga_pkg.sv
// Shared VGA constants, pixel type and helpers for the ROM-picture display path.
package vga_pkg;

  localparam int unsigned H_VALID = 640;
  localparam int unsigned V_VALID = 480;
  localparam int unsigned COORD_W = 10;

  // Coordinate value vga_ctrl drives outside the active area
  localparam logic [COORD_W-1:0] PIX_NONE = 10'h3FF;

  typedef logic [15:0] pixel_t;

  localparam pixel_t BLACK  = 16'h0000;
  localparam pixel_t WHITE  = 16'hFFFF;
  localparam pixel_t RED    = 16'hF800;
  localparam pixel_t GREEN  = 16'h07E0;
  localparam pixel_t BLUE   = 16'h001F;
  localparam pixel_t YELLOW = 16'hFFE0;

  // Image ROM contents: word[i] = i + 1 stands in for the image .mif
  function automatic pixel_t pic_word(input int unsigned addr);
    return 16'(addr + 32'd1);
  endfunction

  // One bounce step along an axis; returns {dir, pos}. Compares in 11 bits.
  function automatic logic [COORD_W:0] bounce(
    input logic [COORD_W-1:0] pos,
    input logic               dir,
    input int unsigned        size,
    input int unsigned        limit,
    input int unsigned        step
  );
    logic [COORD_W:0] p;
    logic [COORD_W:0] s;
    p = 11'(pos);
    s = 11'(step);
    if (dir) begin
      if (p + s + 11'(size) > 11'(limit)) return {1'b0, 10'(p - s)};
      return {1'b1, 10'(p + s)};
    end
    if (p < s) return {1'b1, 10'(p + s)};
    return {1'b0, 10'(p - s)};
  endfunction

endpackage

// File: rtl/pic_rom.sv
// Single-port image ROM wrapper: address registered on rden, output unregistered.
module pic_rom
  import vga_pkg::*;
#(
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clock,
  input  logic [ADDR_W-1:0] address,
  input  logic              rden,
  output pixel_t            q
);

  logic [ADDR_W-1:0] addr_q;

  always_ff @(posedge clock) begin
    if (rden) addr_q <= address;
  end

  assign q = pic_word(32'(addr_q));

endmodule

// File: rtl/vga_pic_rom_rd.sv
// Pixel source for the bouncing ROM picture: maps lookahead (pix_x, pix_y) to
// RGB565 one vga_clk later, image inside the moving window, background elsewhere.
module vga_pic_rom_rd #(
  parameter int unsigned     H_VALID   = vga_pkg::H_VALID,
  parameter int unsigned     V_VALID   = vga_pkg::V_VALID,
  parameter int unsigned     PIC_W     = 100,
  parameter int unsigned     PIC_H     = 100,
  parameter int unsigned     ADDR_W    = 14,
  parameter int unsigned     X0        = 270,
  parameter int unsigned     Y0        = 190,
  parameter int unsigned     STEP      = 1,
  parameter int unsigned     FRAME_DIV = 1,
  parameter vga_pkg::pixel_t BG_COLOR  = vga_pkg::BLACK
) (
  input  logic            vga_clk,
  input  logic            sys_rst_n,
  input  logic [9:0]      pix_x,
  input  logic [9:0]      pix_y,
  output vga_pkg::pixel_t pix_data
);
  import vga_pkg::*;

  localparam int unsigned FCW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  if ((2 ** ADDR_W) < (PIC_W * PIC_H)) begin : g_addr_chk
    $error("ADDR_W too small for PIC_W*PIC_H");
  end

  logic [COORD_W-1:0] img_x, img_y;
  logic               dir_x, dir_y;
  logic [ADDR_W-1:0]  addr_cnt, rd_addr;
  logic [FCW-1:0]     frame_cnt;
  logic               in_win, in_win_d;
  logic               frame_end, frame_wrap;
  logic [COORD_W:0]   px, py, ix, iy;
  logic [COORD_W:0]   nxt_x, nxt_y;
  pixel_t             rom_q;

  // Window hit test and scan address, all from the current lookahead pixel
  always_comb begin
    px = 11'(pix_x);
    py = 11'(pix_y);
    ix = 11'(img_x);
    iy = 11'(img_y);
    in_win = (pix_x != PIX_NONE) && (pix_y != PIX_NONE) &&
             (px >= ix) && (px < ix + 11'(PIC_W)) &&
             (py >= iy) && (py < iy + 11'(PIC_H));
    rd_addr = ((pix_x == img_x) && (pix_y == img_y)) ? '0 : addr_cnt;
    frame_end  = (pix_x == 10'(H_VALID - 1)) && (pix_y == 10'(V_VALID - 1));
    frame_wrap = frame_end && (frame_cnt == FCW'(FRAME_DIV - 1));
    nxt_x = bounce(img_x, dir_x, PIC_W, H_VALID, STEP);
    nxt_y = bounce(img_y, dir_y, PIC_H, V_VALID, STEP);
  end

  // Scan counter, alignment flag and per-frame window motion
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      img_x     <= 10'(X0);
      img_y     <= 10'(Y0);
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
      addr_cnt  <= '0;
      frame_cnt <= '0;
      in_win_d  <= 1'b0;
    end else begin
      in_win_d <= in_win;
      if (in_win) addr_cnt <= rd_addr + ADDR_W'(1);
      if (frame_end) frame_cnt <= frame_wrap ? '0 : frame_cnt + FCW'(1);
      if (frame_wrap) begin
        {dir_x, img_x} <= nxt_x;
        {dir_y, img_y} <= nxt_y;
      end
    end
  end

  pic_rom #(
    .ADDR_W (ADDR_W)
  ) u_rom (
    .clock   (vga_clk),
    .address (rd_addr),
    .rden    (in_win),
    .q       (rom_q)
  );

  assign pix_data = in_win_d ? rom_q : BG_COLOR;

endmodule

// File: tb/tb_vga_pic_rom_rd.sv
// Directed bench for vga_pic_rom_rd: window read-out, background, frame-end motion,
// bounce at the right/bottom edges, frame divider and mid-frame reset recovery.
module tb_vga_pic_rom_rd;
  import vga_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] pix_x, pix_y;
  pixel_t     pd0, pd1, pd2, pd3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vga_pic_rom_rd u0 (
    .vga_clk(clk), .sys_rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pd0));

  vga_pic_rom_rd #(.FRAME_DIV(3)) u1 (
    .vga_clk(clk), .sys_rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pd1));

  vga_pic_rom_rd #(.X0(539), .Y0(379)) u2 (
    .vga_clk(clk), .sys_rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pd2));

  vga_pic_rom_rd #(.X0(0), .Y0(0)) u3 (
    .vga_clk(clk), .sys_rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pd3));

  typedef struct {
    string       name;
    int unsigned inst;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] exp;
  } vec_t;

  vec_t tab[$];

  function automatic void add(input string name, input int unsigned inst,
                              input logic [9:0] x, input logic [9:0] y,
                              input logic [15:0] exp);
    vec_t v;
    v.name = name; v.inst = inst; v.x = x; v.y = y; v.exp = exp;
    tab.push_back(v);
  endfunction

  function automatic logic [15:0] out_of(input int unsigned i);
    case (i)
      0:       return pd0;
      1:       return pd1;
      2:       return pd2;
      default: return pd3;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Present one lookahead coordinate; its pixel is visible just after the next edge
  task automatic step(input logic [9:0] x, input logic [9:0] y);
    pix_x = x;
    pix_y = y;
    @(posedge clk);
    #1;
  endtask

  task automatic run_tab();
    for (int i = 0; i < tab.size(); i++) begin
      step(tab[i].x, tab[i].y);
      check(tab[i].name, 32'(out_of(tab[i].inst)), 32'(tab[i].exp));
    end
    tab.delete();
  endtask

  // Raster the whole u0 window row by row against the golden image word[i] = i + 1
  task automatic scan(input logic [9:0] ox, input logic [9:0] oy, input string tag);
    int          nerr;
    logic [15:0] want;
    nerr = 0;
    for (int y = 0; y < 100; y++) begin
      for (int x = 0; x < 100; x++) begin
        step(10'(ox + 10'(x)), 10'(oy + 10'(y)));
        want = 16'(y * 100 + x + 1);
        if (pd0 !== want) nerr++;
        if (x == 0  && y == 0)  check({tag, "_origin"},       32'(pd0), 32'd1);
        if (x == 99 && y == 0)  check({tag, "_top_right"},    32'(pd0), 32'd100);
        if (x == 0  && y == 1)  check({tag, "_second_row"},   32'(pd0), 32'd101);
        if (x == 99 && y == 99) check({tag, "_bottom_right"}, 32'(pd0), 32'd10000);
      end
    end
    check({tag, "_frame_errors"}, 32'(nerr), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    pix_x = 10'd300;
    pix_y = 10'd200;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pd0", 32'(pd0), 32'h0);
    check("rst_pd1", 32'(pd1), 32'h0);
    check("rst_pd2", 32'(pd2), 32'h0);
    check("rst_pd3", 32'(pd3), 32'h0);
    check("rst_img_x", 32'(u0.img_x), 32'd270);
    check("rst_img_y", 32'(u0.img_y), 32'd190);
    check("rst_dir",   32'({u0.dir_x, u0.dir_y}), 32'b11);
    pix_x = PIX_NONE;
    pix_y = PIX_NONE;
    rst_n = 1'b1;

    // Frame 0 on u0: origin, each window edge, out-of-area markers, held counter
    add("origin",     0, 10'd270, 10'd190, 16'd1);
    add("left_out",   0, 10'd269, 10'd190, 16'd0);
    add("right_out",  0, 10'd370, 10'd190, 16'd0);
    add("below_out",  0, 10'd270, 10'd290, 16'd0);
    add("above_out",  0, 10'd270, 10'd189, 16'd0);
    add("x_none",     0, PIX_NONE, 10'd190, 16'd0);
    add("y_none",     0, 10'd270, PIX_NONE, 16'd0);
    add("addr_held",  0, 10'd271, 10'd190, 16'd2);
    run_tab();

    scan(10'd270, 10'd190, "scan0");

    // Frame end 1: everything with FRAME_DIV=1 moves one step down-right
    step(10'd639, 10'd479);
    check("fe1_bg", 32'(pd0), 32'h0);
    add("u0_origin",   0, 10'd271, 10'd191, 16'd1);
    add("u0_left_out", 0, 10'd270, 10'd191, 16'd0);
    add("u0_top_out",  0, 10'd271, 10'd190, 16'd0);
    add("u1_hold1",    1, 10'd270, 10'd190, 16'd1);
    add("u2_origin",   2, 10'd540, 10'd380, 16'd1);
    add("u2_left_out", 2, 10'd539, 10'd380, 16'd0);
    add("u3_origin",   3, 10'd1,   10'd1,   16'd1);
    add("u3_left_out", 3, 10'd0,   10'd1,   16'd0);
    add("u3_top_out",  3, 10'd1,   10'd0,   16'd0);
    run_tab();
    check("u2_dir_upd1", 32'({u2.dir_x, u2.dir_y}), 32'b11);

    // Frame end 2: u2 window touches the corner and bounces back
    step(10'd639, 10'd479);
    add("u2_bounce",     2, 10'd539, 10'd379, 16'd1);
    add("u2_bounce_out", 2, 10'd538, 10'd379, 16'd0);
    add("u1_hold2",      1, 10'd270, 10'd190, 16'd1);
    add("u0_drift2",     0, 10'd272, 10'd192, 16'd1);
    add("u3_drift2",     3, 10'd2,   10'd2,   16'd1);
    run_tab();
    check("u2_dir_upd2", 32'({u2.dir_x, u2.dir_y}), 32'b00);
    check("u2_img_upd2", 32'({u2.img_x, u2.img_y}), 32'({10'd539, 10'd379}));

    // Frame end 3: divided instance finally moves, u2 keeps heading up-left
    step(10'd639, 10'd479);
    add("u1_moved",     1, 10'd271, 10'd191, 16'd1);
    add("u1_old_out",   1, 10'd270, 10'd190, 16'd0);
    add("u2_left",      2, 10'd538, 10'd378, 16'd1);
    add("u2_right_out", 2, 10'd638, 10'd378, 16'd0);
    add("u0_drift3",    0, 10'd273, 10'd193, 16'd1);
    run_tab();

    // Reset mid-window, release on line 250, then recover on the next frame
    step(10'd300, 10'd200);
    rst_n = 1'b0;
    #1;
    check("midrst_bg", 32'(pd0), 32'h0);
    check("midrst_img", 32'({u0.img_x, u0.img_y}), 32'({10'd270, 10'd190}));
    step(10'd300, 10'd250);
    step(PIX_NONE, PIX_NONE);
    rst_n = 1'b1;
    step(10'd100, 10'd250);
    check("post_rst_out_bg", 32'(pd0), 32'h0);
    step(10'd300, 10'd250);
    step(10'd639, 10'd479);
    scan(10'd271, 10'd191, "scan1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
